// File: rtl/ex_stage_seq.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_seq
// Summary  : Registered execute stage with valid/ready handshakes. ALU ops,
//            branches and jumps finish in one cycle. MUL/DIV/REM share one
//            iterative shift-add / restoring-divide datapath.
//            Define EX_SEQ_SINGLE_CYCLE_MUL_EN to run MUL* combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module ex_stage_seq #(
    parameter int WORD_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int ALU_OP_WIDTH   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [WORD_WIDTH-1:0]     operand_a_i,
    input  logic [WORD_WIDTH-1:0]     operand_b_i,
    input  logic [ALU_OP_WIDTH-1:0]   alu_op_i,
    input  logic                      mdu_en_i,
    input  logic [2:0]                mdu_op_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_i,
    input  logic [WORD_WIDTH-1:0]     pc_i,
    input  logic [WORD_WIDTH-1:0]     pc_imm_i,
    input  logic                      branch_en_i,
    input  logic                      zeroflag_inv_i,
    input  logic                      jump_en_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [WORD_WIDTH-1:0]     wb_data_o,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr_o,
    output logic                      pc_branch_ctrl_o,
    output logic [WORD_WIDTH-1:0]     pc_branch_addr_o,
    output logic                      busy_o
);

    localparam int W     = WORD_WIDTH;
    localparam int SH_W  = $clog2(WORD_WIDTH);
    localparam int CNT_W = $clog2(WORD_WIDTH + 1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_ITER = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;

    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_ADD  = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SUB  = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SLL  = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SLT  = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SLTU = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_XOR  = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SRL  = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_SRA  = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_OR   = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_AND  = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] c_ALU_PASSB = ALU_OP_WIDTH'(10);

    localparam logic [2:0] c_MDU_MUL    = 3'd0;
    localparam logic [2:0] c_MDU_MULH   = 3'd1;
    localparam logic [2:0] c_MDU_MULHSU = 3'd2;
    localparam logic [2:0] c_MDU_MULHU  = 3'd3;
    localparam logic [2:0] c_MDU_DIV    = 3'd4;
    localparam logic [2:0] c_MDU_DIVU   = 3'd5;
    localparam logic [2:0] c_MDU_REM    = 3'd6;
    localparam logic [2:0] c_MDU_REMU   = 3'd7;

    localparam logic [W-1:0] c_MIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] c_ONES = {W{1'b1}};
    localparam logic [W-1:0] c_FOUR = W'(4);

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;
    logic [2:0]                r_op;
    logic [REG_ADDR_WIDTH-1:0] r_rd;
    logic [W-1:0]              r_tgt;
    logic [W-1:0]              r_hi;
    logic [W-1:0]              r_lo;
    logic [W-1:0]              r_opb;
    logic                      r_neg_q;
    logic                      r_neg_r;

    logic                      r_out_valid;
    logic [W-1:0]              r_wb;
    logic [REG_ADDR_WIDTH-1:0] r_rd_out;
    logic                      r_br_ctrl;
    logic [W-1:0]              r_br_addr;

    logic                      w_accept;
    logic                      w_fast_op;
    logic                      w_mdu_accept;
    logic                      w_fix_fire;
    logic                      w_out_free;

    // ------------------------------------------------------------------
    // ALU and branch decision
    // ------------------------------------------------------------------
    logic [W-1:0]    w_alu_res;
    logic [SH_W-1:0] w_shamt;
    logic [W-1:0]    w_alu_wb;
    logic            w_branch_take;
    logic [W-1:0]    w_fast_res;

    assign w_shamt = operand_b_i[SH_W-1:0];

    always_comb begin
        w_alu_res = '0;
        case (alu_op_i)
            c_ALU_ADD:   w_alu_res = operand_a_i + operand_b_i;
            c_ALU_SUB:   w_alu_res = operand_a_i - operand_b_i;
            c_ALU_SLL:   w_alu_res = operand_a_i << w_shamt;
            c_ALU_SLT:   w_alu_res = {{(W-1){1'b0}}, $signed(operand_a_i) < $signed(operand_b_i)};
            c_ALU_SLTU:  w_alu_res = {{(W-1){1'b0}}, operand_a_i < operand_b_i};
            c_ALU_XOR:   w_alu_res = operand_a_i ^ operand_b_i;
            c_ALU_SRL:   w_alu_res = operand_a_i >> w_shamt;
            c_ALU_SRA:   w_alu_res = $unsigned($signed(operand_a_i) >>> w_shamt);
            c_ALU_OR:    w_alu_res = operand_a_i | operand_b_i;
            c_ALU_AND:   w_alu_res = operand_a_i & operand_b_i;
            c_ALU_PASSB: w_alu_res = operand_b_i;
            default:     w_alu_res = '0;
        endcase
    end

    assign w_alu_wb      = jump_en_i ? (pc_i + c_FOUR) : w_alu_res;
    assign w_branch_take = ~mdu_en_i &
                           ((branch_en_i & ((w_alu_res == '0) ^ zeroflag_inv_i)) | jump_en_i);

    // ------------------------------------------------------------------
    // Operand conditioning for the MDU: magnitudes plus result signs
    // ------------------------------------------------------------------
    logic         w_a_signed;
    logic         w_b_signed;
    logic         w_neg_a;
    logic         w_neg_b;
    logic [W-1:0] w_mag_a;
    logic [W-1:0] w_mag_b;
    logic         w_div_op;
    logic         w_div_zero;
    logic         w_div_ovf;

    assign w_a_signed = (mdu_op_i == c_MDU_MULH) | (mdu_op_i == c_MDU_MULHSU) |
                        (mdu_op_i == c_MDU_DIV)  | (mdu_op_i == c_MDU_REM);
    assign w_b_signed = (mdu_op_i == c_MDU_MULH) | (mdu_op_i == c_MDU_DIV) |
                        (mdu_op_i == c_MDU_REM);
    assign w_neg_a    = w_a_signed & operand_a_i[W-1];
    assign w_neg_b    = w_b_signed & operand_b_i[W-1];
    assign w_mag_a    = w_neg_a ? -operand_a_i : operand_a_i;
    assign w_mag_b    = w_neg_b ? -operand_b_i : operand_b_i;
    assign w_div_op   = mdu_op_i[2];
    assign w_div_zero = w_div_op & (operand_b_i == '0);
    assign w_div_ovf  = w_div_op & ~mdu_op_i[0] & (operand_a_i == c_MIN) &
                        (operand_b_i == c_ONES);

`ifdef EX_SEQ_SINGLE_CYCLE_MUL_EN
    logic [2*W-1:0] w_sc_a;
    logic [2*W-1:0] w_sc_b;
    logic [2*W-1:0] w_sc_prod;
    logic [W-1:0]   w_sc_res;

    // Sign-extending to 2W bits makes one unsigned multiply cover all four variants.
    assign w_sc_a    = {{W{w_neg_a}}, operand_a_i};
    assign w_sc_b    = {{W{w_neg_b}}, operand_b_i};
    assign w_sc_prod = w_sc_a * w_sc_b;
    assign w_sc_res  = (mdu_op_i == c_MDU_MUL) ? w_sc_prod[W-1:0] : w_sc_prod[2*W-1:W];
    assign w_fast_op  = ~mdu_en_i | ~mdu_op_i[2];
    assign w_fast_res = mdu_en_i ? w_sc_res : w_alu_wb;
`else
    assign w_fast_op  = ~mdu_en_i;
    assign w_fast_res = w_alu_wb;
`endif

    assign w_accept     = in_valid_i & in_ready_o;
    assign w_mdu_accept = w_accept & ~w_fast_op;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_mdu_accept) begin
                    w_state_nxt = (w_div_zero | w_div_ovf) ? c_ST_FIX : c_ST_ITER;
                end
            end
            c_ST_ITER: begin
                if (r_cnt == CNT_W'(W - 1)) begin
                    w_state_nxt = c_ST_FIX;
                end
            end
            c_ST_FIX: begin
                if (w_fix_fire) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
        if (flush_i) begin
            w_state_nxt = c_ST_IDLE;
        end
    end

    always_comb begin
        w_out_free = ~r_out_valid | out_ready_i;
        in_ready_o = (r_state == c_ST_IDLE) & ~flush_i & w_out_free;
        w_fix_fire = (r_state == c_ST_FIX) & ~flush_i & w_out_free;
        busy_o     = (r_state != c_ST_IDLE);
    end

    // ------------------------------------------------------------------
    // Iterative datapath: r_hi/r_lo hold {product} or {remainder, quotient}
    // ------------------------------------------------------------------
    logic [W:0] w_sum;
    logic [W:0] w_trial;

    assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : {(W+1){1'b0}});
    assign w_trial = {r_hi, r_lo[W-1]} - {1'b0, r_opb};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_tgt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opb   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (w_mdu_accept) begin
            r_op  <= mdu_op_i;
            r_rd  <= rd_addr_i;
            r_tgt <= pc_i + pc_imm_i;
            r_cnt <= '0;
            if (w_div_zero | w_div_ovf) begin
                // Final quotient/remainder are known now; FIX just forwards them.
                r_hi    <= w_div_zero ? operand_a_i : '0;
                r_lo    <= w_div_zero ? c_ONES : c_MIN;
                r_neg_q <= 1'b0;
                r_neg_r <= 1'b0;
            end else begin
                r_hi    <= '0;
                r_lo    <= w_mag_a;
                r_opb   <= w_mag_b;
                r_neg_q <= w_neg_a ^ w_neg_b;
                r_neg_r <= w_neg_a & w_div_op;
            end
        end else if (r_state == c_ST_ITER) begin
            r_cnt <= r_cnt + 1'b1;
            if (!r_op[2]) begin
                r_hi <= w_sum[W:1];
                r_lo <= {w_sum[0], r_lo[W-1:1]};
            end else if (!w_trial[W]) begin
                r_hi <= w_trial[W-1:0];
                r_lo <= {r_lo[W-2:0], 1'b1};
            end else begin
                r_hi <= {r_hi[W-2:0], r_lo[W-1]};
                r_lo <= {r_lo[W-2:0], 1'b0};
            end
        end
    end

    // Sign fix-up and word selection
    logic [2*W-1:0] w_prod;
    logic [2*W-1:0] w_prod_s;
    logic [W-1:0]   w_quo;
    logic [W-1:0]   w_rem;
    logic [W-1:0]   w_mdu_res;

    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_q ? -w_prod : w_prod;
    assign w_quo    = r_neg_q ? -r_lo : r_lo;
    assign w_rem    = r_neg_r ? -r_hi : r_hi;

    always_comb begin
        w_mdu_res = '0;
        case (r_op)
            c_MDU_MUL:                              w_mdu_res = w_prod_s[W-1:0];
            c_MDU_MULH, c_MDU_MULHSU, c_MDU_MULHU:  w_mdu_res = w_prod_s[2*W-1:W];
            c_MDU_DIV, c_MDU_DIVU:                  w_mdu_res = w_quo;
            c_MDU_REM, c_MDU_REMU:                  w_mdu_res = w_rem;
            default:                                w_mdu_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_wb        <= '0;
            r_rd_out    <= '0;
            r_br_ctrl   <= 1'b0;
            r_br_addr   <= '0;
        end else if (flush_i) begin
            r_out_valid <= 1'b0;
        end else if (w_accept & w_fast_op) begin
            r_out_valid <= 1'b1;
            r_wb        <= w_fast_res;
            r_rd_out    <= rd_addr_i;
            r_br_ctrl   <= w_branch_take;
            r_br_addr   <= pc_i + pc_imm_i;
        end else if (w_fix_fire) begin
            r_out_valid <= 1'b1;
            r_wb        <= w_mdu_res;
            r_rd_out    <= r_rd;
            r_br_ctrl   <= 1'b0;
            r_br_addr   <= r_tgt;
        end else if (out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid_o      = r_out_valid;
    assign wb_data_o        = r_wb;
    assign rd_addr_o        = r_rd_out;
    assign pc_branch_ctrl_o = r_br_ctrl;
    assign pc_branch_addr_o = r_br_addr;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage_seq.sv
`default_nettype none
// Testbench for ex_stage_seq: directed vectors, an arithmetic reference model
// with an expected-output queue checked every cycle, plus literal spot checks.
module tb_ex_stage_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [3:0]  alu_op_i;
    logic        mdu_en_i;
    logic [2:0]  mdu_op_i;
    logic [4:0]  rd_addr_i;
    logic [31:0] pc_i;
    logic [31:0] pc_imm_i;
    logic        branch_en_i;
    logic        zeroflag_inv_i;
    logic        jump_en_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] wb_data_o;
    logic [4:0]  rd_addr_o;
    logic        pc_branch_ctrl_o;
    logic [31:0] pc_branch_addr_o;
    logic        busy_o;

    ex_stage_seq dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
        .alu_op_i(alu_op_i), .mdu_en_i(mdu_en_i), .mdu_op_i(mdu_op_i),
        .rd_addr_i(rd_addr_i), .pc_i(pc_i), .pc_imm_i(pc_imm_i),
        .branch_en_i(branch_en_i), .zeroflag_inv_i(zeroflag_inv_i),
        .jump_en_i(jump_en_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .wb_data_o(wb_data_o), .rd_addr_o(rd_addr_o),
        .pc_branch_ctrl_o(pc_branch_ctrl_o), .pc_branch_addr_o(pc_branch_addr_o),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic chk_en = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << b[4:0];
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> b[4:0];
            4'd7:  return $signed(a) >>> b[4:0];
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa;
        longint     sb;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic mdu, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!mdu) return 1;
`ifdef EX_SEQ_SINGLE_CYCLE_MUL_EN
        if (!op[2]) return 1;
`endif
        if (op[2] && (b == 0)) return 2;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    typedef struct {
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        ctrl;
        logic [31:0] addr;
        int          due;
    } exp_t;

    exp_t q[$];
    int   mdu_due = 0;

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        logic exp_valid;
        logic busy_exp;
        logic rdy_exp;
        exp_t e;
        int   lat;
        if (rst) begin
            q.delete();
            mdu_due = 0;
        end else if (chk_en) begin
            exp_valid = (q.size() > 0) && (q[0].due <= cyc);
            busy_exp  = (mdu_due > cyc);
            rdy_exp   = !busy_exp && !flush_i && (!exp_valid || out_ready_i);
            chk("m_out_valid", 32'(out_valid_o), 32'(exp_valid));
            chk("m_busy", 32'(busy_o), 32'(busy_exp));
            chk("m_in_ready", 32'(in_ready_o), 32'(rdy_exp));
            if (exp_valid && out_valid_o) begin
                chk("m_wb_data", wb_data_o, q[0].wb);
                chk("m_rd_addr", 32'(rd_addr_o), 32'(q[0].rd));
                chk("m_br_ctrl", 32'(pc_branch_ctrl_o), 32'(q[0].ctrl));
                chk("m_br_addr", pc_branch_addr_o, q[0].addr);
            end
            if (flush_i) begin
                q.delete();
                mdu_due = 0;
            end else begin
                if (exp_valid && out_ready_i) void'(q.pop_front());
                if (in_valid_i && in_ready_o) begin
                    lat = ref_lat(mdu_en_i, mdu_op_i, operand_a_i, operand_b_i);
                    if (mdu_en_i) e.wb = ref_mdu(mdu_op_i, operand_a_i, operand_b_i);
                    else          e.wb = jump_en_i ? pc_i + 32'd4 : ref_alu(alu_op_i, operand_a_i, operand_b_i);
                    e.ctrl = !mdu_en_i && ((branch_en_i &&
                             ((ref_alu(alu_op_i, operand_a_i, operand_b_i) == 0) ^ zeroflag_inv_i)) || jump_en_i);
                    e.rd   = rd_addr_i;
                    e.addr = pc_i + pc_imm_i;
                    e.due  = cyc + lat;
                    q.push_back(e);
                    if (lat > 1) mdu_due = cyc + lat;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [31:0] g_pc  = 32'h0000_1000;
    logic [31:0] g_imm = 32'h0000_0020;
    logic [4:0]  next_rd = 5'd1;

    task automatic set_in(input logic mdu, input logic [2:0] mop, input logic [3:0] aop,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic br, input logic inv, input logic jmp);
        mdu_en_i = mdu; mdu_op_i = mop; alu_op_i = aop;
        operand_a_i = a; operand_b_i = b;
        branch_en_i = br; zeroflag_inv_i = inv; jump_en_i = jmp;
        rd_addr_i = next_rd; next_rd = next_rd + 5'd1;
        pc_i = g_pc; pc_imm_i = g_imm;
        in_valid_i = 1'b1;
    endtask

    task automatic wait_acc();
        logic done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (in_ready_o) done = 1'b1;
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL accept_timeout: got=no_accept expected=accept");
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drive(input logic mdu, input logic [2:0] mop, input logic [3:0] aop,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic br, input logic inv, input logic jmp);
        set_in(mdu, mop, aop, a, b, br, inv, jmp);
        wait_acc();
    endtask

    // Cycles from the accept edge until out_valid_o is seen; also counts busy cycles.
    task automatic wait_out(output int n, output int nbusy);
        logic seen = 1'b0;
        n = 0; nbusy = 0;
        while (!seen && n < 100) begin
            @(negedge clk);
            n++;
            if (busy_o) nbusy++;
            if (out_valid_o) seen = 1'b1;
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL output_timeout: got=no_valid expected=valid");
        end
    endtask

    int n;
    int nb;
    int vcnt;

    initial begin
        rst = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        operand_a_i = '0; operand_b_i = '0; alu_op_i = '0; mdu_en_i = 1'b0; mdu_op_i = '0;
        rd_addr_i = '0; pc_i = '0; pc_imm_i = '0; branch_en_i = 1'b0;
        zeroflag_inv_i = 1'b0; jump_en_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_br_ctrl", 32'(pc_branch_ctrl_o), 32'd0);
        chk("rst_wb", wb_data_o, 32'd0);
        chk("rst_rd", 32'(rd_addr_o), 32'd0);
        chk("rst_br_addr", pc_branch_addr_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; chk_en = 1'b1;

        // ADD and back-to-back ALU ops
        drive(1'b0, 3'd0, 4'd0, 32'd5, 32'd7, 1'b0, 1'b0, 1'b0);
        chk("add_valid", 32'(out_valid_o), 32'd1);
        chk("add_wb", wb_data_o, 32'd12);
        chk("add_ctrl", 32'(pc_branch_ctrl_o), 32'd0);
        drive(1'b0, 3'd0, 4'd0, 32'd1, 32'd1, 1'b0, 1'b0, 1'b0);
        chk("b2b0", wb_data_o, 32'd2);
        drive(1'b0, 3'd0, 4'd5, 32'hF0, 32'hFF, 1'b0, 1'b0, 1'b0);
        chk("b2b1", wb_data_o, 32'h0F);
        drive(1'b0, 3'd0, 4'd2, 32'd1, 32'd4, 1'b0, 1'b0, 1'b0);
        chk("b2b2", wb_data_o, 32'd16);
        drive(1'b0, 3'd0, 4'd7, 32'h8000_0000, 32'd4, 1'b0, 1'b0, 1'b0);
        chk("b2b3", wb_data_o, 32'hF800_0000);
        chk("b2b3_valid", 32'(out_valid_o), 32'd1);

        // BEQ via SUB
        g_pc = 32'h100; g_imm = 32'hFFFF_FFF0;
        drive(1'b0, 3'd0, 4'd1, 32'd9, 32'd9, 1'b1, 1'b0, 1'b0);
        chk("beq_taken", 32'(pc_branch_ctrl_o), 32'd1);
        chk("beq_addr", pc_branch_addr_o, 32'h0000_00F0);
        drive(1'b0, 3'd0, 4'd1, 32'd9, 32'd8, 1'b1, 1'b0, 1'b0);
        chk("beq_not_taken", 32'(pc_branch_ctrl_o), 32'd0);
        g_pc = 32'h200; g_imm = 32'h40;
        drive(1'b0, 3'd0, 4'd0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1);
        chk("jal_wb", wb_data_o, 32'h204);
        chk("jal_ctrl", 32'(pc_branch_ctrl_o), 32'd1);
        drive(1'b0, 3'd0, 4'd1, 32'd9, 32'd8, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 3'd0, 4'd3, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 4'd4, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b0, 1'b0);

        // MULH -1 * 2
        drive(1'b1, 3'd1, 4'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0, 1'b0);
        wait_out(n, nb);
        chk("mulh_wb", wb_data_o, 32'hFFFF_FFFF);
        chk("mulh_ctrl", 32'(pc_branch_ctrl_o), 32'd0);
`ifdef EX_SEQ_SINGLE_CYCLE_MUL_EN
        chk("mulh_latency", n, 32'd1);
        chk("mulh_busy_cycles", nb, 32'd0);
`else
        chk("mulh_latency", n, 32'd34);
        chk("mulh_busy_cycles", nb, 32'd33);
`endif

        // Overflow and divide-by-zero shortcuts
        drive(1'b1, 3'd4, 4'd0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        wait_out(n, nb);
        chk("div_ovf_wb", wb_data_o, 32'h8000_0000);
        chk("div_ovf_latency", n, 32'd2);
        drive(1'b1, 3'd5, 4'd0, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0);
        wait_out(n, nb);
        chk("divu0_wb", wb_data_o, 32'hFFFF_FFFF);
        chk("divu0_latency", n, 32'd2);
        drive(1'b1, 3'd7, 4'd0, 32'd100, 32'd0, 1'b0, 1'b0, 1'b0);
        wait_out(n, nb);
        chk("remu0_wb", wb_data_o, 32'd100);
        chk("remu0_latency", n, 32'd2);
        drive(1'b1, 3'd6, 4'd0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
        wait_out(n, nb);
        chk("rem_neg_wb", wb_data_o, 32'hFFFF_FFFF);

        // Mixed MDU vectors checked by the model
        drive(1'b1, 3'd0, 4'd0, 32'd12345, 32'd6789, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd3, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd2, 4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 4'd0, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0, 1'b0);
        wait_out(n, nb);
        chk("div_neg_wb", wb_data_o, 32'hFFFF_FFF2);
        drive(1'b1, 3'd6, 4'd0, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd5, 4'd0, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 3'd4, 4'd0, 32'hFFFF_FFFB, 32'd0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 3'd0, 4'd8, 32'h0F0F, 32'hF000, 1'b0, 1'b0, 1'b0);

        // Backpressure
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        drive(1'b0, 3'd0, 4'd0, 32'd1, 32'd2, 1'b0, 1'b0, 1'b0);
        set_in(1'b0, 3'd0, 4'd9, 32'hFF00, 32'h0FF0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_wb", wb_data_o, 32'd3);
            chk("hold_in_ready", 32'(in_ready_o), 32'd0);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready_o), 32'd1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        chk("release_wb", wb_data_o, 32'h0F00);

        // Flush mid-divide
        drive(1'b1, 3'd5, 4'd0, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_valid", 32'(out_valid_o), 32'd0);
        chk("flush_in_ready", 32'(in_ready_o), 32'd1);
        vcnt = 0;
        repeat (40) begin @(negedge clk); if (out_valid_o) vcnt++; end
        chk("flush_no_result", vcnt, 32'd0);

        // Reset mid-divide
        @(posedge clk); #1;
        drive(1'b1, 3'd5, 4'd0, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_valid", 32'(out_valid_o), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready_o), 32'd1);
        vcnt = 0;
        repeat (40) begin @(negedge clk); if (out_valid_o) vcnt++; end
        chk("rst_mid_no_result", vcnt, 32'd0);

        drive(1'b0, 3'd0, 4'd0, 32'd20, 32'd22, 1'b0, 1'b0, 1'b0);
        chk("post_rst_add", wb_data_o, 32'd42);
        repeat (5) @(posedge clk);
        chk("queue_drained", q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
